datamux_arbiter: RTL and testbench
==================================

DATAMUX_ARBITER -- requirements
Module: datamux_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4: number of data-concentrator FIFOs sharing the output.
REQ-002 SHALL have parameter BURST_MAX, default 8: maximum words read from one source per grant (1..255).
REQ-003 SHALL use one clock and an asynchronous, active-low reset: rd_clk and rst_n.
REQ-004 SHALL have port rd_clk, input, 1 bit: clock; the FIFO read-side clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: when high, new grants are allowed.
REQ-007 SHALL have port src_mask, input, N_SRC bits: a 1 makes the source eligible for a grant.
REQ-008 SHALL have port src_empty, input, N_SRC bits: FIFO empty flag of each source.
REQ-009 SHALL have port src_dout, input, 64*N_SRC bits: FIFO data of each source; source i is slice [64i+63:64i].
REQ-010 SHALL have port src_rd_en, output, N_SRC bits: FIFO read strobe of each source.
REQ-011 SHALL have port m_data, output, 64 bits: word sent downstream.
REQ-012 SHALL have port m_valid, output, 1 bit: m_data is valid.
REQ-013 SHALL have port m_ready, input, 1 bit: downstream accepts the word.
REQ-014 SHALL have port grant, output, N_SRC bits: one-hot current owner; all zero when idle.
REQ-015 SHALL have port word_count, output, 32 bits: total words transferred.

Function
REQ-016 SHALL treat the source FIFOs as standard-read: src_dout is valid in the cycle after src_rd_en.
REQ-017 SHALL have FSM states IDLE, ISSUE, CAPTURE and HOLD.
REQ-018 In IDLE, when enable=1 and (src_mask & ~src_empty) is nonzero: pick source g round-robin, searching from last_grant+1 upward with wrap; set grant to one-hot g; clear burst_cnt; go to ISSUE.
REQ-019 In ISSUE: assert src_rd_en[g] for exactly one cycle, then go to CAPTURE; at most one src_rd_en bit is ever high.
REQ-020 In CAPTURE: register src_dout[g] into m_data; set m_valid=1; go to HOLD.
REQ-021 In HOLD: hold m_data and m_valid stable while m_ready=0.
REQ-022 On a HOLD handshake (m_ready=1): clear m_valid; increment burst_cnt and word_count.
REQ-023 After the handshake: go to ISSUE if burst_cnt<BURST_MAX and enable=1 and src_mask[g]=1 and src_empty[g]=0.
REQ-024 Otherwise after the handshake: set last_grant=g, clear grant, go to IDLE.
REQ-025 Latency SHALL be 3 cycles from the IDLE grant to m_valid; sustained throughput SHALL be one word per 3 cycles while m_ready=1.
REQ-026 SHALL never issue src_rd_en to an empty source and never discard a word that was read; a word in flight always completes HOLD.
REQ-027 Dropping enable or src_mask[g] mid-burst SHALL finish the word in flight, then release the grant.
REQ-028 With a single eligible source, that source SHALL be re-granted after BURST_MAX words, passing through one IDLE cycle.
REQ-029 word_count SHALL wrap from 2^32-1 to 0; burst_cnt SHALL be 8 bits wide.

Reset
REQ-030 While rst_n=0: state=IDLE; src_rd_en=0; m_valid=0; m_data=0; grant=0; burst_cnt=0; word_count=0; last_grant=N_SRC-1 (so the first grant goes to source 0).
REQ-031 Reset mid-burst SHALL abort immediately; a word already read is lost, and this is accepted.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding and the default N_SRC and BURST_MAX constants.
REQ-033 The design SHALL contain one sub-module, rr_pick: combinational round-robin pick taking request vector and last_grant, giving one-hot grant and valid.

Verification
REQ-034 Scenario: sources 0 and 2 each hold 3 words, m_ready=1 -> 3 words from source 0, then 3 from source 2; word_count=6; src_rd_en never pulses while its src_empty=1.
REQ-035 Scenario: source 1 holds 20 words, BURST_MAX=8 -> bursts of 8, 8, 4, each separated by one IDLE cycle.
REQ-036 Scenario: all 4 sources hold 10 words, BURST_MAX=8 -> grant order 0,1,2,3,0,1,2,3; each source first gets 8 words, then 2.
REQ-037 Scenario: m_ready held low for 5 cycles in HOLD -> m_data and m_valid are unchanged for those cycles; no src_rd_en.
REQ-038 Scenario: enable dropped during ISSUE of source 3 -> that word is still delivered, then grant=0 and no further reads.
REQ-039 Scenario: rst_n pulsed low during HOLD -> all outputs are 0 in the same cycle; after release, the first grant goes to source 0.

Source files
------------

// File: rtl/datamux_arbiter_pkg.sv
// Purpose: shared constants and FSM state encoding for the data-concentrator arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package datamux_arbiter_pkg;

    localparam int DEF_N_SRC     = 4;
    localparam int DEF_BURST_MAX = 8;
    localparam int DATA_W        = 64;

    // IDLE: choose an owner; ISSUE: pulse the FIFO read; CAPTURE: take the
    // word one cycle later; HOLD: present it until downstream accepts.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

endpackage

// File: rtl/datamux_arbiter_rr_pick.sv
// Purpose: combinational round-robin pick, searching upward from last_i+1 with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to use the result.
// Ports: req_i request vector, last_i index of previous owner,
//        gnt_o one-hot pick (zero when no request), vld_o any request present.
module rr_pick #(
    parameter int N  = 4,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic          vld_o
);

    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        // Offsets 1..N visit every source once, ending on last_i itself so a
        // lone requester is re-picked.
        for (int k = 1; k <= N; k++) begin
            if (!vld_o && req_i[(int'(last_i) + k) % N]) begin
                gnt_o[(int'(last_i) + k) % N] = 1'b1;
                vld_o                          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/datamux_arbiter.sv
// Purpose: round-robin burst arbiter moving 64-bit words from N_SRC standard-read FIFOs to one output.
// Latency: 3 cycles from the IDLE grant to m_valid; one word per 3 cycles sustained.
// Backpressure: m_ready=0 holds the word in HOLD; no further FIFO read is issued until it is accepted.
// Ports: rd_clk/rst_n clock and async active-low reset; enable gates new grants;
//        src_mask/src_empty/src_dout/src_rd_en per-source FIFO read side;
//        m_data/m_valid/m_ready output handshake; grant one-hot owner; word_count total words moved.
module datamux_arbiter
    import datamux_arbiter_pkg::*;
#(
    parameter int N_SRC     = DEF_N_SRC,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic                    rd_clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [N_SRC-1:0]        src_mask,
    input  logic [N_SRC-1:0]        src_empty,
    input  logic [DATA_W*N_SRC-1:0] src_dout,
    output logic [N_SRC-1:0]        src_rd_en,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [N_SRC-1:0]        grant,
    output logic [31:0]             word_count
);

    localparam int LW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    state_e              state_q, state_d;
    logic [N_SRC-1:0]    grant_q, grant_d;
    logic [LW-1:0]       gidx_q, gidx_d;
    logic [LW-1:0]       last_q, last_d;
    logic [7:0]          burst_q, burst_d;
    logic [31:0]         wc_q, wc_d;
    logic [DATA_W-1:0]   mdata_q, mdata_d;
    logic                mvld_q, mvld_d;

    logic [N_SRC-1:0]    pick_gnt;
    logic                pick_vld;
    logic [LW-1:0]       pick_idx;
    logic [8:0]          burst_nxt;

    rr_pick #(.N(N_SRC), .LW(LW)) u_pick (
        .req_i  (src_mask & ~src_empty),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .vld_o  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pick_gnt[i]) pick_idx = LW'(i);
        end
    end

    // One bit wider than burst_cnt so BURST_MAX=255 compares without overflow.
    assign burst_nxt = {1'b0, burst_q} + 9'd1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        burst_d = burst_q;
        wc_d    = wc_q;
        mdata_d = mdata_q;
        mvld_d  = mvld_q;
        case (state_q)
            IDLE: begin
                if (enable && pick_vld) begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    burst_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                mdata_d = src_dout[int'(gidx_q)*DATA_W +: DATA_W];
                mvld_d  = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (m_ready) begin
                    mvld_d  = 1'b0;
                    burst_d = burst_nxt[7:0];
                    wc_d    = wc_q + 32'd1;
                    // Emptiness was checked here, one cycle before the read,
                    // so a read is never issued to an empty FIFO.
                    if (burst_nxt < 9'(BURST_MAX) && enable &&
                        src_mask[gidx_q] && !src_empty[gidx_q]) begin
                        state_d = ISSUE;
                    end else begin
                        last_d  = gidx_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= LW'(N_SRC - 1);
            burst_q <= '0;
            wc_q    <= '0;
            mdata_q <= '0;
            mvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            wc_q    <= wc_d;
            mdata_q <= mdata_d;
            mvld_q  <= mvld_d;
        end
    end

    // Decoded from the state register so the strobe is a clean single-cycle
    // pulse and drops together with the asynchronous reset.
    assign src_rd_en  = (state_q == ISSUE) ? grant_q : '0;
    assign grant      = grant_q;
    assign m_data     = mdata_q;
    assign m_valid    = mvld_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_datamux_arbiter.sv
// Purpose: self-checking bench for datamux_arbiter with FIFO models and an arbitration reference model.
// Latency: n/a.
// Backpressure: m_ready driven fixed or randomly per scenario.
module tb_datamux_arbiter;

    localparam int N  = 4;
    localparam int BM = 8;

    logic              rd_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              m_ready = 1'b0;
    logic [N-1:0]      src_mask = '1;
    logic [N-1:0]      src_empty = '1;
    logic [64*N-1:0]   src_dout = '0;
    logic [N-1:0]      src_rd_en;
    logic [63:0]       m_data;
    logic              m_valid;
    logic [N-1:0]      grant;
    logic [31:0]       word_count;

    always #5 rd_clk = ~rd_clk;

    datamux_arbiter #(.N_SRC(N), .BURST_MAX(BM)) dut (
        .rd_clk     (rd_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .src_mask   (src_mask),
        .src_empty  (src_empty),
        .src_dout   (src_dout),
        .src_rd_en  (src_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .grant      (grant),
        .word_count (word_count)
    );

    typedef struct {int src; logic [63:0] dat; int cyc;} got_t;
    typedef struct {int src; logic [63:0] dat; bit first;} exp_t;

    logic [63:0] fq [N][$];
    got_t        got_q[$];
    exp_t        exp_q[$];
    int          cyc = 0;
    int          viol = 0;
    int          rdcnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always @(posedge rd_clk) cyc <= cyc + 1;

    // FIFO models and output monitor, evaluated mid-cycle.
    always @(negedge rd_clk) begin
        int s;
        if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            s = -1;
            for (int i = 0; i < N; i++) if (grant[i]) s = i;
            if ($countones(grant) != 1) s = -1;
            got_q.push_back('{s, m_data, cyc});
        end
        if ($countones(src_rd_en) > 1) viol++;
        for (int i = 0; i < N; i++) begin
            if (src_rd_en[i] === 1'b1) begin
                rdcnt++;
                if (fq[i].size() == 0) viol++;
                else src_dout[64*i +: 64] = fq[i].pop_front();
            end
        end
        for (int i = 0; i < N; i++) src_empty[i] = (fq[i].size() == 0);
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic apply_reset(input bit clear);
        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; src_mask = '1;
        if (clear) for (int i = 0; i < N; i++) fq[i].delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        got_q.delete(); viol = 0; rdcnt = 0;
    endtask

    task automatic load(input int s, input int n);
        repeat (n) fq[s].push_back({$urandom, $urandom});
    endtask

    // Reference: from preloaded FIFOs, owners rotate upward from the previous
    // owner; each visit takes min(BM, words left) words.
    task automatic build_exp(input logic [N-1:0] mask);
        int rd[N];
        int last, g, n;
        exp_q.delete();
        last = N - 1;
        foreach (rd[i]) rd[i] = 0;
        forever begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                int s;
                s = (last + k) % N;
                if (g < 0 && mask[s] && fq[s].size() > rd[s]) g = s;
            end
            if (g < 0) break;
            n = fq[g].size() - rd[g];
            if (n > BM) n = BM;
            for (int j = 0; j < n; j++) exp_q.push_back('{g, fq[g][rd[g]+j], j == 0});
            rd[g] += n;
            last = g;
        end
    endtask

    task automatic wait_words(input int n, input int budget, input bit rnd, output bit ok);
        int t;
        t = 0;
        while (got_q.size() < n && t < budget) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        n_chk++; if (m_data !== 64'd0) begin n_fail++; $display("FAIL reset_m_data got=%h want=0", m_data); end
        n_chk++; if (grant !== 4'd0) begin n_fail++; $display("FAIL reset_grant got=%b want=0000", grant); end
        n_chk++; if (src_rd_en !== 4'd0) begin n_fail++; $display("FAIL reset_rd_en got=%b want=0000", src_rd_en); end
        n_chk++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL reset_word_count got=%0d want=0", word_count); end
    endtask

    // Fixed-load scenarios with m_ready=1: order, data, latency, 3-cycle spacing
    // inside a burst and one extra IDLE cycle between bursts.
    task automatic test_bursts();
        int tbl [3][N] = '{'{3, 0, 3, 0}, '{0, 20, 0, 0}, '{10, 10, 10, 10}};
        int t0, gap, want_gap, total;
        bit ok;
        for (int sc = 0; sc < 3; sc++) begin
            apply_reset(1'b1);
            total = 0;
            for (int i = 0; i < N; i++) begin load(i, tbl[sc][i]); total += tbl[sc][i]; end
            build_exp('1);
            tick();
            m_ready = 1'b1; enable = 1'b1; t0 = cyc;
            wait_words(exp_q.size(), 3000, 1'b0, ok);
            n_chk++; if (!ok) begin n_fail++; $display("FAIL burst%0d_timeout got=%0d words want=%0d", sc, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_chk++;
                if (got_q[i].src !== exp_q[i].src || got_q[i].dat !== exp_q[i].dat) begin
                    n_fail++;
                    $display("FAIL burst%0d_word%0d got src=%0d dat=%h want src=%0d dat=%h", sc, i, got_q[i].src, got_q[i].dat, exp_q[i].src, exp_q[i].dat);
                end
                gap = (i == 0) ? got_q[0].cyc - t0 : got_q[i].cyc - got_q[i-1].cyc;
                want_gap = (i == 0) ? 3 : (exp_q[i].first ? 4 : 3);
                n_chk++;
                if (gap !== want_gap) begin n_fail++; $display("FAIL burst%0d_gap%0d got=%0d want=%0d", sc, i, gap, want_gap); end
            end
            n_chk++; if (word_count !== 32'(total)) begin n_fail++; $display("FAIL burst%0d_word_count got=%0d want=%0d", sc, word_count, total); end
            repeat (10) tick();
            n_chk++; if (grant !== 4'd0) begin n_fail++; $display("FAIL burst%0d_idle_grant got=%b want=0000", sc, grant); end
            n_chk++; if (rdcnt !== total) begin n_fail++; $display("FAIL burst%0d_reads got=%0d want=%0d", sc, rdcnt, total); end
            n_chk++; if (viol !== 0) begin n_fail++; $display("FAIL burst%0d_rd_violation got=%0d want=0", sc, viol); end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] hold;
        int t, reads0;
        bit ok;
        apply_reset(1'b1);
        load(0, 2);
        build_exp('1);
        tick();
        m_ready = 1'b0; enable = 1'b1;
        t = 0;
        while (m_valid !== 1'b1 && t < 20) begin tick(); t++; end
        n_chk++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout got=%b want=1", m_valid); end
        hold = m_data; reads0 = rdcnt;
        n_chk++; if (hold !== exp_q[0].dat) begin n_fail++; $display("FAIL bp_first_data got=%h want=%h", hold, exp_q[0].dat); end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_chk++;
            if (m_valid !== 1'b1 || m_data !== hold || src_rd_en !== 4'd0) begin
                n_fail++;
                $display("FAIL bp_hold_c%0d got v=%b d=%h rd=%b want v=1 d=%h rd=0000", c, m_valid, m_data, src_rd_en, hold);
            end
        end
        n_chk++; if (rdcnt !== reads0) begin n_fail++; $display("FAIL bp_reads got=%0d want=%0d", rdcnt, reads0); end
        m_ready = 1'b1;
        wait_words(2, 50, 1'b0, ok);
        n_chk++;
        if (!ok || got_q[0].dat !== exp_q[0].dat || got_q[1].dat !== exp_q[1].dat) begin
            n_fail++;
            $display("FAIL bp_drain got=%0d words want=2 matching model", got_q.size());
        end
    endtask

    task automatic test_enable_drop();
        logic [63:0] first;
        int t;
        apply_reset(1'b1);
        load(3, 5);
        first = fq[3][0];
        src_mask = 4'b1000;
        tick();
        m_ready = 1'b1; enable = 1'b1;
        t = 0;
        do begin tick(); t++; end while (src_rd_en[3] !== 1'b1 && t < 20);
        enable = 1'b0;
        repeat (15) tick();
        n_chk++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL endrop_count got=%0d want=1", got_q.size()); end
        n_chk++;
        if (got_q.size() < 1 || got_q[0].src !== 3 || got_q[0].dat !== first) begin
            n_fail++; $display("FAIL endrop_word got=%0d words want src=3 dat=%h", got_q.size(), first);
        end
        n_chk++; if (grant !== 4'd0) begin n_fail++; $display("FAIL endrop_grant got=%b want=0000", grant); end
        n_chk++; if (rdcnt !== 1) begin n_fail++; $display("FAIL endrop_reads got=%0d want=1", rdcnt); end
        n_chk++; if (word_count !== 32'd1) begin n_fail++; $display("FAIL endrop_word_count got=%0d want=1", word_count); end
    endtask

    task automatic test_reset_mid_burst();
        int t;
        apply_reset(1'b1);
        load(0, 1);
        load(1, 3);
        tick();
        m_ready = 1'b1; enable = 1'b1;
        t = 0;
        while (grant !== 4'b0010 && t < 40) begin tick(); t++; end
        m_ready = 1'b0;
        t = 0;
        while (m_valid !== 1'b1 && t < 20) begin tick(); t++; end
        n_chk++; if (m_valid !== 1'b1 || grant !== 4'b0010) begin n_fail++; $display("FAIL rstmid_setup got v=%b g=%b want v=1 g=0010", m_valid, grant); end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (m_valid !== 1'b0 || m_data !== 64'd0 || grant !== 4'd0 || src_rd_en !== 4'd0 || word_count !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got v=%b d=%h g=%b rd=%b wc=%0d want all 0", m_valid, m_data, grant, src_rd_en, word_count);
        end
        load(0, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        t = 0;
        while (grant === 4'd0 && t < 20) begin tick(); t++; end
        n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rstmid_first_grant got=%b want=0001", grant); end
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            apply_reset(1'b1);
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) load(i, $urandom_range(0, 12));
            src_mask = mask;
            build_exp(mask);
            tick();
            enable = 1'b1;
            wait_words(exp_q.size(), 5000, 1'b1, ok);
            m_ready = 1'b1;
            repeat (6) tick();
            n_chk++; if (!ok || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count got=%0d want=%0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_chk++;
                if (got_q[i].src !== exp_q[i].src || got_q[i].dat !== exp_q[i].dat) begin
                    n_fail++;
                    $display("FAIL rnd%0d_word%0d got src=%0d dat=%h want src=%0d dat=%h", it, i, got_q[i].src, got_q[i].dat, exp_q[i].src, exp_q[i].dat);
                end
            end
            n_chk++; if (word_count !== 32'(exp_q.size())) begin n_fail++; $display("FAIL rnd%0d_word_count got=%0d want=%0d", it, word_count, exp_q.size()); end
            n_chk++; if (viol !== 0) begin n_fail++; $display("FAIL rnd%0d_rd_violation got=%0d want=0", it, viol); end
        end
    endtask

    initial begin
        test_reset();
        test_bursts();
        test_backpressure();
        test_enable_drop();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
